or1200_vlx_packer: RTL and testbench

Parametrised variable-length bit packer that supersedes the fixed single-bit set-bit engine inside the OR1200 load/store unit. It accepts codes of 0..MAX_BITS bits per CPU operation into an MSB-first bit buffer and emits aligned stores of STORE_W bits through the LSU data port, auto-incrementing the target address. It adds multi-bit puts, zero/one padding on flush and SPR-visible status and bit counting. It sits between the LSU and the data-cache interface and stalls the CPU while stores drain.

---
 rtl/or1200_vlx_packer.sv | 152 +++++++++++++++
 tb/tb_or1200_vlx_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_packer.sv
// Variable-length MSB-first bit packer for the OR1200 LSU: collects 0..MAX_BITS-bit codes
// and drains them as auto-addressed STORE_W-bit stores, with SPR control and status.
module or1200_vlx_packer #(
  parameter  int MAX_BITS = 16,
  parameter  int STORE_W  = 8,
  parameter  int BUF_W    = 32,
  parameter  int PAD_ONES = 0,
  localparam int NB_W     = $clog2(MAX_BITS + 1),
  localparam int FILL_W   = $clog2(BUF_W + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                put_i,
  input  logic [NB_W-1:0]     num_bits_i,
  input  logic [MAX_BITS-1:0] dat_i,
  output logic                stall_cpu_o,
  output logic                store_o,
  output logic [31:0]         addr_o,
  output logic [STORE_W-1:0]  dat_o,
  input  logic                ack_i,
  input  logic                spr_cs,
  input  logic                spr_write,
  input  logic [1:0]          spr_addr,
  input  logic [31:0]         spr_dat_i,
  output logic [31:0]         spr_dat_o
);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_FLUSH} state_t;

  state_t              r_state;
  logic [BUF_W-1:0]    r_buf;
  logic [FILL_W-1:0]   r_fill;
  logic [31:0]         r_addr;
  logic [31:0]         r_bitcnt;
  logic [STORE_W-1:0]  r_dat;

  state_t              w_state_nxt;
  logic [BUF_W-1:0]    w_buf_nxt;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic [FILL_W-1:0]   w_fill_drain;
  logic [FILL_W-1:0]   w_sh;
  logic [31:0]         w_addr_nxt;
  logic [31:0]         w_bitcnt_nxt;
  logic [STORE_W-1:0]  w_dat_nxt;
  logic [STORE_W-1:0]  w_top;
  logic [STORE_W-1:0]  w_pad;
  logic [NB_W-1:0]     w_n;
  logic [MAX_BITS-1:0] w_code;
  logic                w_idle;
  logic                w_put;
  logic                w_spr_wr;
  logic                w_flush_req;
  logic [31:0]         w_fill32;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    w_n = (num_bits_i > NB_W'(MAX_BITS)) ? NB_W'(MAX_BITS) : num_bits_i;
    for (int i = 0; i < MAX_BITS; i++) w_code[i] = dat_i[i] && (i < int'(w_n));
    w_idle       = (r_state == S_IDLE);
    w_spr_wr     = spr_cs && spr_write && w_idle;
    w_flush_req  = w_spr_wr && (spr_addr == 2'd2) && spr_dat_i[0];
    w_put        = put_i && w_idle && (w_n != '0);
    w_sh         = FILL_W'(BUF_W) - r_fill - FILL_W'(w_n);
    w_fill_drain = r_fill - FILL_W'(STORE_W);
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_fill_nxt   = r_fill;
    w_addr_nxt   = r_addr;
    w_bitcnt_nxt = r_bitcnt;

    case (r_state)
      S_IDLE: begin
        // Code lands directly below the valid bits; bits under the fill stay zero.
        if (w_put) begin
          w_buf_nxt    = r_buf | (BUF_W'(w_code) << w_sh);
          w_fill_nxt   = r_fill + FILL_W'(w_n);
          w_bitcnt_nxt = r_bitcnt + 32'(w_n);
        end
        if (w_spr_wr) begin
          case (spr_addr)
            2'd0:    w_addr_nxt = spr_dat_i;
            2'd1:    begin w_buf_nxt = '0; w_fill_nxt = '0; end
            2'd3:    w_bitcnt_nxt = '0;
            default: ;
          endcase
        end
        if (w_fill_nxt >= FILL_W'(STORE_W))          w_state_nxt = S_STORE;
        else if (w_flush_req && w_fill_nxt != '0)    w_state_nxt = S_FLUSH;
      end
      S_STORE: if (ack_i) begin
        w_buf_nxt   = r_buf << STORE_W;
        w_fill_nxt  = w_fill_drain;
        w_addr_nxt  = r_addr + 32'(STORE_W / 8);
        w_state_nxt = (w_fill_drain >= FILL_W'(STORE_W)) ? S_STORE : S_IDLE;
      end
      S_FLUSH: if (ack_i) begin
        w_buf_nxt   = '0;
        w_fill_nxt  = '0;
        w_addr_nxt  = r_addr + 32'(STORE_W / 8);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush pad covers the STORE_W - fill low bits; fill is below STORE_W whenever we flush.
    w_top = w_buf_nxt[BUF_W-1 -: STORE_W];
    w_pad = (PAD_ONES != 0) ? ({STORE_W{1'b1}} >> w_fill_nxt) : '0;
    case (w_state_nxt)
      S_STORE: w_dat_nxt = w_top;
      S_FLUSH: w_dat_nxt = w_top | w_pad;
      default: w_dat_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_fill   <= '0;
      r_addr   <= '0;
      r_bitcnt <= '0;
      r_dat    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_fill   <= w_fill_nxt;
      r_addr   <= w_addr_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_dat    <= w_dat_nxt;
    end
  end

  assign store_o     = (r_state != S_IDLE);
  assign stall_cpu_o = (r_state != S_IDLE);
  assign addr_o      = r_addr;
  assign dat_o       = r_dat;
  assign w_fill32    = 32'(r_fill);

  always_comb begin
    spr_dat_o = '0;
    if (spr_cs) begin
      case (spr_addr)
        2'd0: spr_dat_o = r_addr;
        2'd1: spr_dat_o = w_fill32;
        2'd2: spr_dat_o = {16'h0, w_fill32[7:0], 7'h0, !w_idle};
        2'd3: spr_dat_o = r_bitcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_vlx_packer.sv
// Directed bench for or1200_vlx_packer: default, PAD_ONES=1 and STORE_W=16 instances share stimulus.
module tb_or1200_vlx_packer;

  logic        clk = 1'b0;
  logic        rst, put, ack, spr_cs, spr_write;
  logic [4:0]  nb;
  logic [15:0] dat;
  logic [1:0]  spr_addr;
  logic [31:0] spr_wdat;

  logic        stall0, store0, stall1, store1, stall2, store2;
  logic [31:0] addr0, addr1, addr2, sprd0, sprd1, sprd2;
  logic [7:0]  dat0, dat1;
  logic [15:0] dat2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  or1200_vlx_packer dut0 (
    .clk_i(clk), .rst_i(rst), .put_i(put), .num_bits_i(nb), .dat_i(dat),
    .stall_cpu_o(stall0), .store_o(store0), .addr_o(addr0), .dat_o(dat0), .ack_i(ack),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr), .spr_dat_i(spr_wdat), .spr_dat_o(sprd0));

  or1200_vlx_packer #(.PAD_ONES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .put_i(put), .num_bits_i(nb), .dat_i(dat),
    .stall_cpu_o(stall1), .store_o(store1), .addr_o(addr1), .dat_o(dat1), .ack_i(ack),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr), .spr_dat_i(spr_wdat), .spr_dat_o(sprd1));

  or1200_vlx_packer #(.STORE_W(16)) dut2 (
    .clk_i(clk), .rst_i(rst), .put_i(put), .num_bits_i(nb), .dat_i(dat),
    .stall_cpu_o(stall2), .store_o(store2), .addr_o(addr2), .dat_o(dat2), .ack_i(ack),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr), .spr_dat_i(spr_wdat), .spr_dat_o(sprd2));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; put = 1'b0; ack = 1'b0; spr_cs = 1'b0; spr_write = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_put(input logic [4:0] n, input logic [15:0] d);
    put = 1'b1; nb = n; dat = d;
    step();
    put = 1'b0;
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_wdat = d;
    step();
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic spr_rd(input logic [1:0] a);
    spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; put = 1'b0; ack = 1'b0; spr_cs = 1'b0; spr_write = 1'b0;
    nb = '0; dat = '0; spr_addr = '0; spr_wdat = '0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL rst_store: got %0h exp 0", store0); end
    n_checks++; if (stall0 !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %0h exp 0", stall0); end
    n_checks++; if (addr0 !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h exp 0", addr0); end
    n_checks++; if (dat0 !== 8'h0) begin n_errors++; $display("FAIL rst_dat: got %h exp 0", dat0); end
    n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL rst_spr_idle: got %h exp 0", sprd0); end
    for (int a = 0; a < 4; a++) begin
      spr_rd(2'(a));
      n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL rst_spr%0d: got %h exp 0", a, sprd0); end
    end
    spr_cs = 1'b0;
  endtask

  task automatic test_basic_put();
    do_reset();
    spr_wr(2'd0, 32'h1000);
    do_put(5'd3, 16'h0005);
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL put_partial_store: got %0h exp 0", store0); end
    do_put(5'd5, 16'h0013);
    n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL put_store: got %0h exp 1", store0); end
    n_checks++; if (stall0 !== 1'b1) begin n_errors++; $display("FAIL put_stall: got %0h exp 1", stall0); end
    n_checks++; if (dat0 !== 8'hB3) begin n_errors++; $display("FAIL put_dat: got %h exp b3", dat0); end
    n_checks++; if (addr0 !== 32'h1000) begin n_errors++; $display("FAIL put_addr: got %h exp 1000", addr0); end
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++; if (stall0 !== 1'b0) begin n_errors++; $display("FAIL put_stall_drop: got %0h exp 0", stall0); end
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL put_store_drop: got %0h exp 0", store0); end
    n_checks++; if (addr0 !== 32'h1001) begin n_errors++; $display("FAIL put_addr_inc: got %h exp 1001", addr0); end
    spr_rd(2'd3);
    n_checks++; if (sprd0 !== 32'd8) begin n_errors++; $display("FAIL put_bitcount: got %0d exp 8", sprd0); end
    spr_cs = 1'b0;
    // Stray ack while idle must not move the address.
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++; if (addr0 !== 32'h1001) begin n_errors++; $display("FAIL idle_ack_addr: got %h exp 1001", addr0); end
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL idle_ack_store: got %0h exp 0", store0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    spr_wr(2'd0, 32'h1000);
    do_put(5'd16, 16'hABCD);
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL b2b_hold_store c%0d: got %0h exp 1", c, store0); end
      n_checks++; if (dat0 !== 8'hAB) begin n_errors++; $display("FAIL b2b_hold_dat c%0d: got %h exp ab", c, dat0); end
      n_checks++; if (addr0 !== 32'h1000) begin n_errors++; $display("FAIL b2b_hold_addr c%0d: got %h exp 1000", c, addr0); end
      if (c == 4) ack = 1'b1;
      step();
    end
    n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL b2b_second_store: got %0h exp 1", store0); end
    n_checks++; if (dat0 !== 8'hCD) begin n_errors++; $display("FAIL b2b_second_dat: got %h exp cd", dat0); end
    n_checks++; if (addr0 !== 32'h1001) begin n_errors++; $display("FAIL b2b_second_addr: got %h exp 1001", addr0); end
    step(); ack = 1'b0;
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL b2b_done_store: got %0h exp 0", store0); end
    n_checks++; if (addr0 !== 32'h1002) begin n_errors++; $display("FAIL b2b_done_addr: got %h exp 1002", addr0); end
    spr_rd(2'd3);
    n_checks++; if (sprd0 !== 32'd16) begin n_errors++; $display("FAIL b2b_bitcount: got %0d exp 16", sprd0); end
    spr_cs = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    do_put(5'd3, 16'h0006);
    spr_wr(2'd2, 32'h1);
    n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL flush_store: got %0h exp 1", store0); end
    n_checks++; if (dat0 !== 8'hC0) begin n_errors++; $display("FAIL flush_dat_zero_pad: got %h exp c0", dat0); end
    n_checks++; if (dat1 !== 8'hDF) begin n_errors++; $display("FAIL flush_dat_one_pad: got %h exp df", dat1); end
    spr_rd(2'd2);
    n_checks++; if (sprd0 !== 32'h301) begin n_errors++; $display("FAIL flush_ctrl_busy: got %h exp 301", sprd0); end
    spr_cs = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL flush_done_store: got %0h exp 0", store0); end
    n_checks++; if (addr0 !== 32'h1) begin n_errors++; $display("FAIL flush_addr: got %h exp 1", addr0); end
    spr_rd(2'd1);
    n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL flush_fill: got %h exp 0", sprd0); end
    spr_cs = 1'b0;
    spr_wr(2'd2, 32'h1);
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL empty_flush_store: got %0h exp 0", store0); end
    n_checks++; if (stall0 !== 1'b0) begin n_errors++; $display("FAIL empty_flush_stall: got %0h exp 0", stall0); end
    step();
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL empty_flush_later: got %0h exp 0", store0); end
  endtask

  task automatic test_length_and_busy();
    do_reset();
    do_put(5'd0, 16'hFFFF);
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL zero_len_store: got %0h exp 0", store0); end
    spr_rd(2'd1);
    n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL zero_len_fill: got %h exp 0", sprd0); end
    spr_rd(2'd3);
    n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL zero_len_bitcount: got %h exp 0", sprd0); end
    spr_cs = 1'b0;
    do_put(5'd20, 16'hF0F0);
    n_checks++; if (dat0 !== 8'hF0) begin n_errors++; $display("FAIL clamp_dat: got %h exp f0", dat0); end
    // put and an address write while busy must both be dropped.
    put = 1'b1; nb = 5'd8; dat = 16'h00FF;
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 2'd0; spr_wdat = 32'h5555;
    step();
    put = 1'b0; spr_cs = 1'b0; spr_write = 1'b0;
    n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL busy_store: got %0h exp 1", store0); end
    n_checks++; if (addr0 !== 32'h0) begin n_errors++; $display("FAIL busy_addr: got %h exp 0", addr0); end
    spr_rd(2'd1);
    n_checks++; if (sprd0 !== 32'd16) begin n_errors++; $display("FAIL busy_fill: got %0d exp 16", sprd0); end
    spr_rd(2'd3);
    n_checks++; if (sprd0 !== 32'd16) begin n_errors++; $display("FAIL clamp_bitcount: got %0d exp 16", sprd0); end
    spr_cs = 1'b0;
    ack = 1'b1; step();
    n_checks++; if (dat0 !== 8'hF0) begin n_errors++; $display("FAIL clamp_second_dat: got %h exp f0", dat0); end
    n_checks++; if (addr0 !== 32'h1) begin n_errors++; $display("FAIL clamp_second_addr: got %h exp 1", addr0); end
    step(); ack = 1'b0;
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL clamp_done_store: got %0h exp 0", store0); end
    n_checks++; if (addr0 !== 32'h2) begin n_errors++; $display("FAIL clamp_done_addr: got %h exp 2", addr0); end
  endtask

  task automatic test_wide_wrap();
    do_reset();
    spr_wr(2'd0, 32'hFFFF_FFFE);
    do_put(5'd16, 16'h1234);
    n_checks++; if (store2 !== 1'b1) begin n_errors++; $display("FAIL w16_store: got %0h exp 1", store2); end
    n_checks++; if (dat2 !== 16'h1234) begin n_errors++; $display("FAIL w16_dat: got %h exp 1234", dat2); end
    n_checks++; if (addr2 !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL w16_addr: got %h exp fffffffe", addr2); end
    ack = 1'b1; step(); ack = 1'b0;
    n_checks++; if (store2 !== 1'b0) begin n_errors++; $display("FAIL w16_done_store: got %0h exp 0", store2); end
    n_checks++; if (addr2 !== 32'h0) begin n_errors++; $display("FAIL w16_wrap_addr: got %h exp 0", addr2); end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    spr_wr(2'd0, 32'h1000);
    do_put(5'd8, 16'h00A5);
    n_checks++; if (store0 !== 1'b1) begin n_errors++; $display("FAIL mid_pre_store: got %0h exp 1", store0); end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (store0 !== 1'b0) begin n_errors++; $display("FAIL mid_store: got %0h exp 0", store0); end
    n_checks++; if (stall0 !== 1'b0) begin n_errors++; $display("FAIL mid_stall: got %0h exp 0", stall0); end
    n_checks++; if (dat0 !== 8'h0) begin n_errors++; $display("FAIL mid_dat: got %h exp 0", dat0); end
    n_checks++; if (addr0 !== 32'h0) begin n_errors++; $display("FAIL mid_addr: got %h exp 0", addr0); end
    for (int a = 0; a < 4; a++) begin
      spr_rd(2'(a));
      n_checks++; if (sprd0 !== 32'h0) begin n_errors++; $display("FAIL mid_spr%0d: got %h exp 0", a, sprd0); end
    end
    spr_cs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_put();
    test_back_to_back();
    test_flush();
    test_length_and_busy();
    test_wide_wrap();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
